// File: rtl/frame_writer_if.sv
// Framebuffer write port: one request/acknowledge handshake carrying an address and a pixel word.
// The writer drives it through the master modport and the memory uses the slave modport.
interface frame_writer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ack;

  modport master (output mem_req, mem_addr, mem_data, input mem_ack);
  modport slave  (input mem_req, mem_addr, mem_data, output mem_ack);
endinterface

// File: rtl/frame_writer.sv
// Raster pixel sink: maps (x,y) to a linear address, queues writes in a FIFO and drains them to memory.
// Define RGB565_EN to pack pixels as 16-bit RGB565; the default build writes 24-bit RGB888 unchanged.
module frame_writer #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int          ADDR_W     = 19,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [9:0]    in_x,
  input  logic [9:0]    in_y,
  input  logic [23:0]   in_pixel,
  input  logic          in_done,
  frame_writer_if.master mem,
  output logic          frame_done,
  output logic          overflow,
  output logic [18:0]   pix_count
);

`ifdef RGB565_EN
  localparam int DATA_W = 16;
`else
  localparam int DATA_W = 24;
`endif
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic              accept;
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] pix_data;

  logic              stage_valid;
  logic [ADDR_W-1:0] stage_addr;
  logic [DATA_W-1:0] stage_data;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic               fifo_empty, fifo_full;
  logic               push, pop, drop;
  logic [ENTRY_W-1:0] head;

  assign accept = ((state == IDLE) || (state == RUN)) && in_valid &&
                  (32'(in_x) < H_RES) && (32'(in_y) < V_RES);

  // Constant multiply; synthesis reduces it to shifts and adds for H_RES=640.
  assign pix_addr = ADDR_W'(in_y) * ADDR_W'(H_RES) + ADDR_W'(in_x);

`ifdef RGB565_EN
  assign pix_data = {in_pixel[23:19], in_pixel[15:10], in_pixel[7:3]};
`else
  assign pix_data = in_pixel;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_data  <= '0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_addr <= pix_addr;
        stage_data <= pix_data;
      end
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop        = mem.mem_req && mem.mem_ack;
  // A full FIFO still takes the staged entry when the head leaves in the same cycle.
  assign push       = stage_valid && (!fifo_full || pop);
  assign drop       = stage_valid && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {stage_addr, stage_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      pix_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      if (pop && (pix_count != '1)) pix_count <= pix_count + 19'd1;
    end
  end

  assign head         = fifo_mem[rd_ptr];
  assign mem.mem_req  = !fifo_empty;
  assign mem.mem_addr = fifo_empty ? '0 : head[ENTRY_W-1:DATA_W];
  assign mem.mem_data = fifo_empty ? '0 : head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (in_done) state_next = DRAIN;
      DRAIN:   if (fifo_empty && !stage_valid && !mem.mem_req) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_frame_writer.sv
// Directed self-checking bench for frame_writer: reset, mapping, range filter, backpressure,
// full-FIFO concurrency, mid-frame reset and a multi-line raster ending at the last frame address.
module tb_frame_writer;

`ifdef RGB565_EN
  localparam int          DATA_W   = 16;
  localparam logic [31:0] MAP_DATA = 32'h0000F800;
`else
  localparam int          DATA_W   = 24;
  localparam logic [31:0] MAP_DATA = 32'h00FF0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [9:0]  in_x;
  logic [9:0]  in_y;
  logic [23:0] in_pixel;
  logic        in_done;
  logic        frame_done;
  logic        overflow;
  logic [18:0] pix_count;

  int checks = 0;
  int errors = 0;
  int unsigned exp_q[$];
  int unsigned last_addr;

  always #5 clk = ~clk;

  frame_writer_if #(.ADDR_W(19), .DATA_W(DATA_W)) bus ();

  frame_writer #(
    .H_RES(640), .V_RES(480), .ADDR_W(19), .FIFO_DEPTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_pixel   (in_pixel),
    .in_done    (in_done),
    .mem        (bus.master),
    .frame_done (frame_done),
    .overflow   (overflow),
    .pix_count  (pix_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input int x, input int y,
                               input logic [23:0] p, input logic d);
    in_valid = v;
    in_x     = 10'(x);
    in_y     = 10'(y);
    in_pixel = p;
    in_done  = d;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.mem_ack = 1'b0;
    applyStimulus(1'b0, 0, 0, 24'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hold ack high and collect writes; each observed request completes at the next edge.
  task automatic drainCheck(input string tag, input int first, input int expected_n);
    int n = 0;
    bus.mem_ack = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (bus.mem_req) begin
        checkOutput({tag, " addr"}, 32'(bus.mem_addr), 32'(first + n));
        n++;
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    checkOutput({tag, " count"}, 32'(n), 32'(expected_n));
  endtask

  task automatic rasterStep();
    int unsigned e;
    if (bus.mem_req) begin
      if (exp_q.size() == 0) begin
        checkOutput("raster spurious req", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("raster addr", 32'(bus.mem_addr), e);
        last_addr = e;
      end
    end
  endtask

  initial begin
    int lines [5] = '{0, 1, 2, 3, 479};
    int guard;
    rst_n       = 1'b0;
    bus.mem_ack = 1'b0;
    applyStimulus(1'b0, 0, 0, 24'h0, 1'b0);
    doReset();

    checkOutput("reset mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("reset mem_data", 32'(bus.mem_data), 32'd0);
    checkOutput("reset frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset pix_count", 32'(pix_count), 32'd0);

    // Single-pixel mapping and latency
    applyStimulus(1'b1, 5, 2, 24'hFF0000, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 0, 0, 24'h0, 1'b0);
    checkOutput("map req after 1 edge", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    checkOutput("map req after 2 edges", 32'(bus.mem_req), 32'd1);
    checkOutput("map addr", 32'(bus.mem_addr), 32'd1285);
    checkOutput("map data", 32'(bus.mem_data), MAP_DATA);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checkOutput("map pix_count", 32'(pix_count), 32'd1);
    checkOutput("map req cleared", 32'(bus.mem_req), 32'd0);
    in_done = 1'b1;
    @(negedge clk);
    checkOutput("map frame_done in drain", 32'(frame_done), 32'd0);
    @(negedge clk);
    in_done = 1'b0;
    checkOutput("map frame_done", 32'(frame_done), 32'd1);

    // Out-of-range coordinates are discarded silently
    doReset();
    applyStimulus(1'b1, 640, 0, 24'h123456, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 0, 480, 24'h654321, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 0, 0, 24'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("range no req", 32'(bus.mem_req), 32'd0);
    end
    checkOutput("range overflow", 32'(overflow), 32'd0);

    // Backpressure: 20 pixels with ack low
    doReset();
    for (int i = 0; i < 20; i++) begin
      if (i >= 1) begin
        checkOutput("bp mem_req", 32'(bus.mem_req), (i >= 2) ? 32'd1 : 32'd0);
        checkOutput("bp overflow", 32'(overflow), (i >= 10) ? 32'd1 : 32'd0);
        if (i >= 2) checkOutput("bp addr stable", 32'(bus.mem_addr), 32'd0);
      end
      applyStimulus(1'b1, i, 0, 24'(i), 1'b0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 0, 0, 24'h0, 1'b0);
    checkOutput("bp overflow end", 32'(overflow), 32'd1);
    @(negedge clk);
    drainCheck("bp drain", 0, 8);
    checkOutput("bp pix_count", 32'(pix_count), 32'd8);

    // Full FIFO with simultaneous push and pop
    doReset();
    for (int i = 0; i < 13; i++) begin
      if (i == 9) checkOutput("ff overflow at full", 32'(overflow), 32'd0);
      bus.mem_ack = (i >= 9);
      applyStimulus(1'b1, i, 0, 24'(i), 1'b0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 0, 0, 24'h0, 1'b0);
    @(negedge clk);
    checkOutput("ff overflow", 32'(overflow), 32'd0);
    checkOutput("ff pix_count", 32'(pix_count), 32'd5);
    drainCheck("ff drain", 5, 8);
    checkOutput("ff pix_count end", 32'(pix_count), 32'd13);

    // Reset with five entries queued
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, i + 100, 7, 24'hABCDEF, 1'b0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 0, 0, 24'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid queued req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid reset req", 32'(bus.mem_req), 32'd0);
    checkOutput("mid reset addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("mid reset pix_count", 32'(pix_count), 32'd0);
    checkOutput("mid reset frame_done", 32'(frame_done), 32'd0);

    // New frame: lines 0..3 and the last line at full rate with ack held high
    exp_q.delete();
    last_addr   = 0;
    bus.mem_ack = 1'b1;
    for (int li = 0; li < 5; li++) begin
      for (int x = 0; x < 640; x++) begin
        rasterStep();
        applyStimulus(1'b1, x, lines[li], 24'(x * 3 + li), (li == 4) && (x == 639));
        exp_q.push_back(32'(lines[li] * 640 + x));
        @(negedge clk);
      end
    end
    applyStimulus(1'b0, 0, 0, 24'h0, 1'b0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      rasterStep();
      @(negedge clk);
      guard++;
    end
    checkOutput("raster drain timeout", 32'(exp_q.size()), 32'd0);
    checkOutput("raster last addr", last_addr, 32'd307199);
    checkOutput("raster frame_done at last ack", 32'(frame_done), 32'd0);
    checkOutput("raster req idle", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    checkOutput("raster frame_done", 32'(frame_done), 32'd1);
    checkOutput("raster pix_count", 32'(pix_count), 32'd3200);
    checkOutput("raster overflow", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Downstream sink for the pixel generator. Each cycle it samples the raster coordinate and 24-bit pixel, maps the coordinate to a linear framebuffer address, and queues the write in a small FIFO. It then drains the FIFO to a framebuffer memory port over a req/ack handshake. It signals frame completion once the generator's `done` is seen and every queued write has been acknowledged.

## Interface
Parameters:
- `H_RES`, 640, active pixels per line.
- `V_RES`, 480, active lines per frame.
- `ADDR_W`, 19, framebuffer address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES.
- `FIFO_DEPTH`, 8, write-queue entries; must be a power of 2.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `in_valid`  in  1  pixel/coordinate valid this cycle.
- `in_x`  in  10  column, 0..H_RES-1.
- `in_y`  in  10  line, 0..V_RES-1.
- `in_pixel`  in  24  RGB888, with R in [23:16].
- `in_done`  in  1  generator frame-complete level.
- `mem_req`  out  1  write request.
- `mem_addr`  out  ADDR_W  write address.
- `mem_data`  out  DATA_W  write data. DATA_W is 24, or 16 with `RGB565_EN`.
- `mem_ack`  in  1  memory accepts the current request.
- `frame_done`  out  1  sticky: frame fully written.
- `overflow`  out  1  sticky: at least one pixel was dropped.
- `pix_count`  out  19  number of acknowledged writes.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN: first cycle with `in_valid`=1.
  - RUN→DRAIN: `in_done`=1 is sampled.
  - DRAIN→DONE: FIFO empty, stage register empty and no pending request.
  - DONE holds until reset.
- Acceptance:
  - In IDLE/RUN, a pixel is accepted when `in_valid`=1, `in_x`<H_RES and `in_y`<V_RES.
  - Out-of-range coordinates are silently discarded and do not set `overflow`.
  - In DRAIN/DONE, `in_valid` is ignored.
- Simultaneous `in_valid` and `in_done`: the pixel is accepted, then the FSM enters DRAIN.
- Stage register: holds addr = in_y*H_RES + in_x (ADDR_W bits, no wrap, since in-range is guaranteed) plus the converted data.
- FIFO push:
  - The stage contents are pushed on the next edge.
  - If the FIFO is full and no pop happens that cycle, the entry is dropped and `overflow`←1.
  - Push and pop in the same cycle while full: legal, no drop.
- Memory handshake:
  - `mem_req` = FIFO non-empty; `mem_addr`/`mem_data` = FIFO head.
  - These stay stable while `mem_req`=1 and `mem_ack`=0.
  - A write completes on a cycle with `mem_req`=1 and `mem_ack`=1: the head is popped and `pix_count` increments.
  - `mem_ack` while `mem_req`=0 is ignored.
- `pix_count` saturates at 2^19-1.
- Reset values: `mem_req`=0, `mem_addr`=0, `mem_data`=0, `frame_done`=0, `overflow`=0, `pix_count`=0. FIFO and stage are empty; state is IDLE.
- Reset mid-frame discards all queued writes; no partial request remains asserted after the reset edge.

## Timing
- A pixel sampled at edge N is in the stage register after N and in the FIFO after N+1.
- Into an empty FIFO, `mem_req`=1 from edge N+1, giving 2-cycle latency from sample to request.
- Throughput is 1 write/cycle with `mem_ack` held high. The FIFO then never grows beyond 1 entry, so there are no drops at the full raster rate.
- `frame_done` rises on the edge after the DRAIN→DONE condition holds. With `mem_ack`=1, that is 1 cycle after the final ack.
- The multiply `in_y*H_RES` must close in one cycle. With H_RES=640 it reduces to (y<<9)+(y<<7).

## Configuration
- `RGB565_EN` defined:
  - DATA_W=16.
  - `mem_data` = {R[7:3], G[7:2], B[7:3]}, i.e. {in_pixel[23:19], in_pixel[15:10], in_pixel[7:3]}.
- `RGB565_EN` undefined:
  - DATA_W=24.
  - `mem_data` = `in_pixel` unchanged.
- Addressing and handshake are identical in both builds.

## Test plan
- Full frame, `mem_ack`≡1, raster 0..639 × 0..479, then `in_done`=1:
  - 307200 writes, with the last `mem_addr`=307199.
  - `pix_count`=307200, `overflow`=0.
  - `frame_done`=1 one cycle after the last ack.
- Mapping: single pixel x=5, y=2, pixel 24'hFF0000.
  - Default build: `mem_addr`=1285, `mem_data`=24'hFF0000.
  - `RGB565_EN` build: `mem_data`=16'hF800.
  - `mem_req` rises 2 cycles after the sample.
- Backpressure: continuous input with `mem_ack`=0 for 20 cycles.
  - `mem_req`=1 and `mem_addr`=0 held stable throughout.
  - `overflow`=1 after the FIFO has held 8 entries.
  - On releasing ack, exactly 8 writes drain with addresses 0..7.
- Range filter: x=640, y=0 and x=0, y=480 with `in_valid`=1 → no `mem_req`, `overflow`=0.
- Full-FIFO concurrency: fill to 8, then assert `in_valid` and `mem_ack` together → `overflow` stays 0 and occupancy stays 8.
- Reset mid-frame: `rst_n`=0 for 1 cycle with 5 entries queued → next cycle `mem_req`=0, `pix_count`=0, `frame_done`=0, state IDLE. A new frame then runs normally.
